// File: rtl/aurora_hls_nfc_pkg.sv
// Shared types and constants for the Aurora NFC pause arbiter.
package aurora_hls_nfc_pkg;

    typedef enum logic [2:0] {
        RESET,
        RUNNING,
        SEND_XOFF,
        PAUSED,
        SEND_XON
    } nfc_state_t;

    localparam logic [15:0] NFC_XOFF = 16'hFFFF;
    localparam logic [15:0] NFC_XON  = 16'h0000;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/aurora_hls_nfc_refresh_timer.sv
// Pause refresh timer: restarts on every XOFF handshake, counts while paused
// and holds at its terminal count until the next restart.
module aurora_hls_nfc_refresh_timer #(
    parameter int unsigned CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic tc
);

    localparam int unsigned W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign tc = (count_reg == LAST);

endmodule

// File: rtl/aurora_hls_nfc_arbiter.sv
// Arbitrates NUM_REQ pause requesters onto one Aurora NFC stream port.
// Optional XOFF refresh enabled by defining AURORA_HLS_NFC_REFRESH_EN.
module aurora_hls_nfc_arbiter
    import aurora_hls_nfc_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned REFRESH_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               counter_reset,
    input  logic [NUM_REQ-1:0] req_xoff,
    input  logic               s_axi_nfc_tready,
    output logic               s_axi_nfc_tvalid,
    output logic [0:15]        s_axi_nfc_tdata,
    output logic               link_paused,
    output logic [NUM_REQ-1:0] pause_cause,
    output logic [31:0]        xoff_count,
    output logic [31:0]        xon_count,
    output logic [31:0]        max_pause_cycles,
    output logic [31:0]        refresh_count
);

    nfc_state_t         state_reg;
    nfc_state_t         state_next;
    logic [NUM_REQ-1:0] req_q_reg;
    logic               link_paused_reg;
    logic [NUM_REQ-1:0] pause_cause_reg;
    logic [31:0]        xoff_count_reg;
    logic [31:0]        xon_count_reg;
    logic [31:0]        max_pause_reg;
    logic [31:0]        pause_ctr_reg;

    logic aggregate;
    logic xoff_hs;
    logic xon_hs;
    logic refresh_tc;
    logic in_pause_window;

    assign aggregate       = |req_q_reg;
    assign xoff_hs         = (state_reg == SEND_XOFF) && s_axi_nfc_tready;
    assign xon_hs          = (state_reg == SEND_XON) && s_axi_nfc_tready;
    assign in_pause_window = (state_reg == PAUSED) || (state_reg == SEND_XON);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q_reg <= '0;
        end else begin
            req_q_reg <= req_xoff;
        end
    end

`ifdef AURORA_HLS_NFC_REFRESH_EN
    logic [31:0] refresh_count_reg;

    aurora_hls_nfc_refresh_timer #(
        .CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (xoff_hs),
        .enable  (state_reg == PAUSED),
        .tc      (refresh_tc)
    );

    // A refresh XOFF is one sent while the link is already paused.
    always_ff @(posedge clk) begin
        if (!rst_n || counter_reset) begin
            refresh_count_reg <= '0;
        end else if (xoff_hs && link_paused_reg) begin
            refresh_count_reg <= refresh_count_reg + 32'd1;
        end
    end

    assign refresh_count = refresh_count_reg;
`else
    logic unused_refresh_cfg;

    assign unused_refresh_cfg = (REFRESH_CYCLES < 4);
    assign refresh_tc         = 1'b0;
    assign refresh_count      = '0;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state; frames in flight are never retracted
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RESET:     state_next = RUNNING;
            RUNNING:   if (aggregate) state_next = SEND_XOFF;
            SEND_XOFF: if (s_axi_nfc_tready) state_next = PAUSED;
            PAUSED: begin
                if (!aggregate) begin
                    state_next = SEND_XON;
                end else if (refresh_tc) begin
                    state_next = SEND_XOFF;
                end
            end
            SEND_XON:  if (s_axi_nfc_tready) state_next = RUNNING;
            default:   state_next = RESET;
        endcase
    end

    // FSM: outputs; tdata is a pure state decode so it is stable while tvalid waits
    always_comb begin
        s_axi_nfc_tvalid = 1'b0;
        s_axi_nfc_tdata  = NFC_XON;
        case (state_reg)
            SEND_XOFF: begin
                s_axi_nfc_tvalid = 1'b1;
                s_axi_nfc_tdata  = NFC_XOFF;
            end
            SEND_XON: begin
                s_axi_nfc_tvalid = 1'b1;
                s_axi_nfc_tdata  = NFC_XON;
            end
            default: begin
                s_axi_nfc_tvalid = 1'b0;
                s_axi_nfc_tdata  = NFC_XON;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            link_paused_reg <= 1'b0;
            pause_cause_reg <= '0;
        end else begin
            if (xoff_hs) begin
                link_paused_reg <= 1'b1;
            end else if (xon_hs) begin
                link_paused_reg <= 1'b0;
            end
            if ((state_reg == RUNNING) && aggregate) begin
                pause_cause_reg <= req_q_reg;
            end
        end
    end

    // Statistics; counter_reset takes priority over any same-cycle update
    always_ff @(posedge clk) begin
        if (!rst_n || counter_reset) begin
            xoff_count_reg <= '0;
            xon_count_reg  <= '0;
            max_pause_reg  <= '0;
            pause_ctr_reg  <= '0;
        end else begin
            if (xoff_hs) begin
                xoff_count_reg <= xoff_count_reg + 32'd1;
            end
            if (xon_hs) begin
                xon_count_reg <= xon_count_reg + 32'd1;
                if (pause_ctr_reg > max_pause_reg) begin
                    max_pause_reg <= pause_ctr_reg;
                end
            end
            if (xoff_hs && !link_paused_reg) begin
                pause_ctr_reg <= '0;
            end else if (in_pause_window) begin
                pause_ctr_reg <= sat_inc32(pause_ctr_reg);
            end
        end
    end

    assign link_paused      = link_paused_reg;
    assign pause_cause      = pause_cause_reg;
    assign xoff_count       = xoff_count_reg;
    assign xon_count        = xon_count_reg;
    assign max_pause_cycles = max_pause_reg;

endmodule
